// File: rtl/note_judge_pkg.sv
// Shared constants and types for the rhythm-game note judge.
// Holds lane count, life/combo/score limits and FSM encodings.
package note_judge_pkg;

  localparam int NUM_LANES = 4;
  localparam int LIVES_INIT = 5;
  localparam int COMBO_MAX = 127;
  localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/bcd_score_adder.sv
// Saturating four-digit BCD increment by 0..4.
// Any carry out of the thousands digit clamps to 9999.
module bcd_score_adder
  import note_judge_pkg::*;
(
  input  logic [15:0] score,
  input  logic [2:0]  inc,
  output logic [15:0] sum
);

  logic [4:0] c;
  logic [4:0] d;

  always_comb begin
    c = {2'b00, inc};
    d = '0;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, score[i*4 +: 4]} + c;
      if (d > 5'd9) begin
        sum[i*4 +: 4] = 4'(d - 5'd10);
        c = 5'd1;
      end else begin
        sum[i*4 +: 4] = d[3:0];
        c = 5'd0;
      end
    end
    if (c != 5'd0) sum = SCORE_MAX_BCD;
  end

endmodule

// File: rtl/note_judge.sv
// Judges button presses against pending notes; keeps score,
// combo and lives, and runs the IDLE/RUN/OVER game FSM.
module note_judge
  import note_judge_pkg::*;
(
  input  logic                 INPUTCLOCK,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 step,
  input  logic [NUM_LANES-1:0] lane_note,
  input  logic [NUM_LANES-1:0] key_n,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 bad_pulse,
  output logic [15:0]          score_bcd,
  output logic [6:0]           combo,
  output logic [2:0]           lives,
  output logic [1:0]           state
);

  state_t st_q, st_d;

  logic [NUM_LANES-1:0] sync1, sync2, hist, press;
  logic [NUM_LANES-1:0] pending, hits, bads;
  logic [1:0]  fill;
  logic [2:0]  nhits;
  logic        run, miss, enter_run;
  logic [15:0] score_sum;
  logic [7:0]  combo_sum;
  logic [6:0]  combo_d;
  logic [2:0]  lives_d;

  // fill masks edges until the sync chain holds real samples,
  // so a key held low through reset yields no press
  always_ff @(posedge INPUTCLOCK) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
      hist  <= '1;
      fill  <= 2'd0;
      press <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      hist  <= sync2;
      fill  <= fill + {1'b0, fill != 2'd3};
      press <= hist & ~sync2 & {NUM_LANES{fill == 2'd3}};
    end
  end

  bcd_score_adder u_add (
    .score (score_bcd),
    .inc   (nhits),
    .sum   (score_sum)
  );

  always_comb begin
    run       = (st_q == ST_RUN);
    hits      = press & pending & {NUM_LANES{run}};
    bads      = press & ~pending & {NUM_LANES{run}};
    nhits     = popcount4(hits);
    miss      = run & step & (|(pending & ~hits));
    combo_sum = {1'b0, combo} + 8'(nhits);
    combo_d   = combo_sum[6:0];
    if (combo_sum > 8'(COMBO_MAX)) combo_d = 7'(COMBO_MAX);
    if ((|bads) || miss) combo_d = 7'd0;
    lives_d = lives;
    if (miss && lives != 3'd0) lives_d = lives - 3'd1;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE, ST_OVER: if (start) st_d = ST_RUN;
      ST_RUN:  if (miss && lives == 3'd1) st_d = ST_OVER;
      default: st_d = ST_IDLE;
    endcase
    enter_run = (st_q != ST_RUN) && (st_d == ST_RUN);
  end

  always_ff @(posedge INPUTCLOCK) begin
    if (!reset_n) begin
      st_q       <= ST_IDLE;
      score_bcd  <= '0;
      combo      <= '0;
      lives      <= 3'(LIVES_INIT);
      pending    <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      bad_pulse  <= 1'b0;
    end else begin
      st_q       <= st_d;
      hit_pulse  <= |hits;
      miss_pulse <= miss;
      bad_pulse  <= |bads;
      if (enter_run) begin
        score_bcd <= '0;
        combo     <= '0;
        lives     <= 3'(LIVES_INIT);
        pending   <= '0;
      end else if (run) begin
        score_bcd <= score_sum;
        combo     <= combo_d;
        lives     <= lives_d;
        pending   <= step ? lane_note : (pending & ~hits);
      end
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_note_judge.sv
// Directed self-checking bench for note_judge.
// Linear scenario sequence with hand-computed expectations.
module tb_note_judge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic [3:0]  lane_note = 4'h0;
  logic [3:0]  key_n = 4'hf;
  logic        hit_pulse, miss_pulse, bad_pulse;
  logic [15:0] score_bcd;
  logic [6:0]  combo;
  logic [2:0]  lives;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  note_judge dut (
    .INPUTCLOCK (clk),
    .reset_n    (reset_n),
    .start      (start),
    .step       (step),
    .lane_note  (lane_note),
    .key_n      (key_n),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .bad_pulse  (bad_pulse),
    .score_bcd  (score_bcd),
    .combo      (combo),
    .lives      (lives),
    .state      (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_step(input logic [3:0] note);
    step = 1'b1;
    lane_note = note;
    tick();
    step = 1'b0;
    lane_note = 4'h0;
  endtask

  // key low, then four edges: pulse is visible after the 4th
  task automatic press_begin(input logic [3:0] mask);
    key_n = ~mask;
    repeat (4) tick();
  endtask

  task automatic release_keys();
    key_n = 4'hf;
    repeat (3) tick();
  endtask

  task automatic pulses(input string tag, input logic h,
                        input logic m, input logic b);
    check({tag, "_hit"}, {31'd0, hit_pulse}, {31'd0, h});
    check({tag, "_miss"}, {31'd0, miss_pulse}, {31'd0, m});
    check({tag, "_bad"}, {31'd0, bad_pulse}, {31'd0, b});
  endtask

  initial begin
    repeat (2) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_combo", 32'(combo), 32'd0);
    check("rst_lives", 32'(lives), 32'd5);
    pulses("rst", 1'b0, 1'b0, 1'b0);

    reset_n = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_state", 32'(state), 32'd1);
    check("start_lives", 32'(lives), 32'd5);

    // single hit on lane 0
    do_step(4'b0001);
    key_n = 4'b1110;
    repeat (3) tick();
    check("hit0_early", {31'd0, hit_pulse}, 32'd0);
    tick();
    pulses("hit0", 1'b1, 1'b0, 1'b0);
    check("hit0_score", 32'(score_bcd), 32'h0001);
    check("hit0_combo", 32'(combo), 32'd1);
    release_keys();

    // two lanes at once
    do_step(4'b1010);
    check("s1010_miss", {31'd0, miss_pulse}, 32'd0);
    press_begin(4'b1010);
    pulses("dbl", 1'b1, 1'b0, 1'b0);
    check("dbl_score", 32'(score_bcd), 32'h0003);
    check("dbl_combo", 32'(combo), 32'd3);
    tick();
    check("dbl_once", {31'd0, hit_pulse}, 32'd0);
    release_keys();
    do_step(4'b0000);
    check("dbl_nomiss", {31'd0, miss_pulse}, 32'd0);
    check("dbl_lives", 32'(lives), 32'd5);

    // press coincident with step
    do_step(4'b0100);
    key_n = 4'b1011;
    repeat (3) tick();
    step = 1'b1;
    lane_note = 4'b0000;
    tick();
    step = 1'b0;
    pulses("coin", 1'b1, 1'b0, 1'b0);
    check("coin_score", 32'(score_bcd), 32'h0004);
    check("coin_combo", 32'(combo), 32'd4);
    check("coin_lives", 32'(lives), 32'd5);
    release_keys();

    // bad press with nothing pending
    press_begin(4'b0001);
    pulses("bad", 1'b0, 1'b0, 1'b1);
    check("bad_combo", 32'(combo), 32'd0);
    check("bad_score", 32'(score_bcd), 32'h0004);
    release_keys();

    // hit and bad in the same cycle
    do_step(4'b0001);
    press_begin(4'b0011);
    pulses("mix", 1'b1, 1'b0, 1'b1);
    check("mix_score", 32'(score_bcd), 32'h0005);
    check("mix_combo", 32'(combo), 32'd0);
    release_keys();
    do_step(4'b0000);

    // misses until game over
    do_step(4'b0100);
    do_step(4'b0100);
    check("miss1_pulse", {31'd0, miss_pulse}, 32'd1);
    check("miss1_lives", 32'(lives), 32'd4);
    check("miss1_combo", 32'(combo), 32'd0);
    repeat (3) do_step(4'b0100);
    check("miss4_lives", 32'(lives), 32'd1);
    check("miss4_state", 32'(state), 32'd1);
    do_step(4'b0100);
    check("over_lives", 32'(lives), 32'd0);
    check("over_state", 32'(state), 32'd2);
    do_step(4'b0100);
    check("over_step_miss", {31'd0, miss_pulse}, 32'd0);
    check("over_step_lives", 32'(lives), 32'd0);
    press_begin(4'b0100);
    pulses("over_press", 1'b0, 1'b0, 1'b0);
    check("over_score", 32'(score_bcd), 32'h0005);
    release_keys();

    // restart and drive score to saturation
    start = 1'b1;
    tick();
    start = 1'b0;
    check("re_state", 32'(state), 32'd1);
    check("re_score", 32'(score_bcd), 32'h0);
    check("re_lives", 32'(lives), 32'd5);
    repeat (3) begin
      do_step(4'hf);
      press_begin(4'hf);
      release_keys();
    end
    check("bcd12", 32'(score_bcd), 32'h0012);
    check("combo12", 32'(combo), 32'd12);
    repeat (2496) begin
      do_step(4'hf);
      press_begin(4'hf);
      release_keys();
    end
    do_step(4'b0011);
    press_begin(4'b0011);
    release_keys();
    check("s9998", 32'(score_bcd), 32'h9998);
    check("combo_sat", 32'(combo), 32'd127);
    do_step(4'b0011);
    press_begin(4'b0011);
    check("s9999", 32'(score_bcd), 32'h9999);
    release_keys();
    do_step(4'b0111);
    press_begin(4'b0111);
    check("s9999_hold", 32'(score_bcd), 32'h9999);
    check("combo_hold", 32'(combo), 32'd127);
    release_keys();

    // reset mid-game with a key held low
    do_step(4'b0001);
    key_n = 4'b1110;
    tick();
    reset_n = 1'b0;
    repeat (2) tick();
    check("mrst_state", 32'(state), 32'd0);
    check("mrst_score", 32'(score_bcd), 32'h0);
    check("mrst_combo", 32'(combo), 32'd0);
    check("mrst_lives", 32'(lives), 32'd5);
    reset_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("mrst_nohit", {31'd0, hit_pulse}, 32'd0);
      check("mrst_nobad", {31'd0, bad_pulse}, 32'd0);
      tick();
    end
    check("mrst_run_score", 32'(score_bcd), 32'h0);
    key_n = 4'hf;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
